keypad_scanner: RTL

Scans a 4x4 matrix hex keypad by driving one column low at a time and reading the active-low rows. It debounces the result into a single one-cycle `key_valid` strobe with a 4-bit hex `key_code`, and optionally shifts accepted digits into a 32-bit entry word. It is the input-side counterpart of the 8-digit seven-segment display driver: the display scans digits out, this block scans keys in, and the `entry` word can feed the display's 32-bit value directly.

---
 rtl/keypad_scanner.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column strobe, row synchronizer, scan-level debounce FSM.
// Define KEYPAD_ENTRY_EN to build the 32-bit hex digit entry shift register.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  input  logic        entry_clr,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] entry
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [3:0]    rows_meta_reg;
  logic [3:0]    rows_sync_reg;
  logic [DW-1:0] div_reg;
  logic [1:0]    col_reg;
  logic [15:0]   snap_reg;
  logic          scan_done_reg;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    cand_reg;
  logic [3:0]    key_code_reg;
  logic          key_valid_reg;
  logic          key_held_reg;

  // Rows idle high, so the synchronizer resets to the released state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_reg <= 4'hF;
      rows_sync_reg <= 4'hF;
    end else begin
      rows_meta_reg <= rows;
      rows_sync_reg <= rows_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg       <= '0;
      col_reg       <= 2'd0;
      snap_reg      <= 16'hFFFF;
      scan_done_reg <= 1'b0;
    end else begin
      scan_done_reg <= 1'b0;
      if (div_reg == DIV_LAST) begin
        div_reg                       <= '0;
        col_reg                       <= col_reg + 2'd1;
        snap_reg[{col_reg, 2'b00} +: 4] <= rows_sync_reg;
        scan_done_reg                 <= (col_reg == 2'd3);
      end else begin
        div_reg <= div_reg + DIV_ONE;
      end
    end
  end

  assign cols = ~(4'b0001 << col_reg);

  // Snapshot bit 4*col+row; a lone low bit maps to key code 4*row+col.
  logic       any_low;
  logic       multi_low;
  logic [3:0] low_idx;
  logic [3:0] snap_key;

  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    low_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_reg[i]) begin
        if (any_low) multi_low = 1'b1;
        any_low = 1'b1;
        low_idx = 4'(i);
      end
    end
  end

  assign snap_key = {low_idx[1:0], low_idx[3:2]};

  logic snap_single;
  logic snap_none;
  assign snap_single = any_low && !multi_low;
  assign snap_none   = !any_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cand_reg      <= 4'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      if (scan_done_reg) begin
        case (state_reg)
          IDLE: begin
            if (snap_single) begin
              cand_reg <= snap_key;
              if (DEBOUNCE == 1) begin
                state_reg     <= HELD;
                cnt_reg       <= CNT_MAX;
                key_code_reg  <= snap_key;
                key_valid_reg <= 1'b1;
                key_held_reg  <= 1'b1;
              end else begin
                state_reg <= PRESS_WAIT;
                cnt_reg   <= CNT_ONE;
              end
            end
          end
          PRESS_WAIT: begin
            if (snap_single && snap_key == cand_reg) begin
              if (cnt_reg + CNT_ONE == CNT_MAX) begin
                state_reg     <= HELD;
                cnt_reg       <= CNT_MAX;
                key_code_reg  <= cand_reg;
                key_valid_reg <= 1'b1;
                key_held_reg  <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end else begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end
          HELD: begin
            // Any key activity keeps the hold; there is no auto-repeat.
            if (snap_none) begin
              if (DEBOUNCE == 1) begin
                state_reg    <= IDLE;
                cnt_reg      <= '0;
                key_held_reg <= 1'b0;
              end else begin
                state_reg <= RELEASE_WAIT;
                cnt_reg   <= CNT_ONE;
              end
            end
          end
          RELEASE_WAIT: begin
            if (snap_none) begin
              if (cnt_reg + CNT_ONE == CNT_MAX) begin
                state_reg    <= IDLE;
                cnt_reg      <= '0;
                key_held_reg <= 1'b0;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end else begin
              state_reg <= HELD;
              cnt_reg   <= CNT_MAX;
            end
          end
          default: begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            key_held_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

`ifdef KEYPAD_ENTRY_EN
  logic [31:0] entry_reg;

  // A clear in the accept cycle wins over shifting the new digit in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_reg <= 32'h0;
    end else if (entry_clr) begin
      entry_reg <= 32'h0;
    end else if (key_valid_reg) begin
      entry_reg <= {entry_reg[27:0], key_code_reg};
    end
  end

  assign entry = entry_reg;
`else
  logic entry_clr_unused;
  assign entry_clr_unused = entry_clr;
  assign entry = 32'h0;
`endif

endmodule
